// File: rtl/tt_um_pwm.sv
// tt_um_pwm: Tiny Tapeout PWM generator with preset or custom duty cycle.
//
// Ports
//   clk      system clock
//   rst_n    synchronous reset, active high (1 = reset asserted)
//   ena      design enable from the harness
//   ui_in    [2:0] preset select, [3] mode (1 = custom duty), [7:4] prescale
//   uio_in   custom duty value (used when mode = 1)
//   uo_out   [0] pwm, [1] inverted pwm, [2] wrap pulse, [5:3] active select,
//            [6] active mode, [7] 0
//   uio_out  constant 0
//   uio_oe   constant 0 (all uio pins are inputs)
//
// The period is 2**CNT_W counts, each count lasting (prescale + 1) clocks.
// Duty, prescale, select and mode are captured into shadow registers only at
// the period wrap, so a setting change never produces a runt pulse.

module tt_um_pwm #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] duty_a;
  logic [PRE_W-1:0] pre_a;
  logic [2:0]       sel_a;
  logic             mode_a;

  logic             pwm_q;
  logic             pwm_n_q;
  logic             wrap_q;

  logic [2:0]       sel_live;
  logic             mode_live;
  logic [PRE_W-1:0] pre_live;
  logic [CNT_W-1:0] duty_live;

  logic             tick;
  logic             last_cnt;
  logic             pwm_next;

  assign sel_live  = ui_in[2:0];
  assign mode_live = ui_in[3];
  assign pre_live  = ui_in[4 +: PRE_W];

  // Presets place the select value in the top three bits: 0, 1/8, ... 7/8.
  always_comb begin
    duty_live = '0;
    if (mode_live) begin
      duty_live = uio_in[CNT_W-1:0];
    end else begin
      duty_live = {sel_live, {(CNT_W-3){1'b0}}};
    end
  end

  assign tick     = (pre_cnt == pre_a) & ena;
  assign last_cnt = (cnt == {CNT_W{1'b1}});
  assign pwm_next = (cnt < duty_a);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
      wrap_q  <= 1'b0;
      // Track live inputs so the first period after release uses them.
      duty_a  <= duty_live;
      pre_a   <= pre_live;
      sel_a   <= sel_live;
      mode_a  <= mode_live;
    end else if (ena) begin
      if (tick) begin
        pre_cnt <= '0;
        cnt     <= cnt + 1'b1;
        if (last_cnt) begin
          duty_a <= duty_live;
          pre_a  <= pre_live;
          sel_a  <= sel_live;
          mode_a <= mode_live;
        end
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      pwm_q   <= pwm_next;
      // Separate register keeps the inverted output low during and right
      // after reset instead of idling high.
      pwm_n_q <= ~pwm_next;
      wrap_q  <= tick & last_cnt;
    end else begin
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  // Gating with ena makes the outputs drop in the same cycle ena falls.
  assign uo_out[0]   = pwm_q & ena;
  assign uo_out[1]   = pwm_n_q & ena;
  assign uo_out[2]   = wrap_q & ena;
  assign uo_out[5:3] = sel_a;
  assign uo_out[6]   = mode_a;
  assign uo_out[7]   = 1'b0;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_pwm.sv
module tb_tt_um_pwm;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int uio_errs = 0;

  tt_um_pwm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    int         nclk;    // clocks measured (two full periods)
    int         highs;   // expected clocks with pwm high
    int         wraps;   // expected wrap pulses
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) uio_errs++;
  endtask

  // Hold reset for two clocks with the given inputs, check the reset-state
  // outputs, then release reset (the next edge is the first counting edge).
  task automatic do_reset(input logic [7:0] ui, input logic [7:0] uio, input string name);
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = ui;
    uio_in = uio;
    step();
    step();
    check({name, "_rst_uo"}, int'(uo_out), int'({1'b0, ui[3], ui[2:0], 3'b000}));
    rst_n = 1'b0;
  endtask

  // Run n clocks counting pwm-high clocks, wrap pulses and static errors.
  task automatic run(input int n, output int highs, output int wraps, output int errs,
                     input logic [3:0] exp_sel_mode);
    highs = 0;
    wraps = 0;
    errs  = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (uo_out[0] === 1'b1) highs++;
      if (uo_out[2] === 1'b1) wraps++;
      if (uo_out[1] !== ~uo_out[0]) errs++;
      if (uo_out[7] !== 1'b0) errs++;
      if (uo_out[6:3] !== exp_sel_mode) errs++;
    end
  endtask

  initial begin
    int h, w, e;
    int h2, w2, e2;

    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    vecs[0] = '{ui: 8'h04, uio: 8'h00, nclk: 512,  highs: 256,  wraps: 2};
    vecs[1] = '{ui: 8'h00, uio: 8'h00, nclk: 512,  highs: 0,    wraps: 2};
    vecs[2] = '{ui: 8'h08, uio: 8'hFF, nclk: 512,  highs: 510,  wraps: 2};
    vecs[3] = '{ui: 8'h08, uio: 8'h01, nclk: 512,  highs: 2,    wraps: 2};
    vecs[4] = '{ui: 8'h34, uio: 8'h00, nclk: 2048, highs: 1024, wraps: 2};
    vecs[5] = '{ui: 8'h07, uio: 8'h55, nclk: 512,  highs: 448,  wraps: 2};
    vecs[6] = '{ui: 8'h1B, uio: 8'h80, nclk: 1024, highs: 512,  wraps: 2};

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_reset(vecs[i].ui, vecs[i].uio, nm);
      run(vecs[i].nclk, h, w, e, {vecs[i].ui[3], vecs[i].ui[2:0]});
      check({nm, "_highs"}, h, vecs[i].highs);
      check({nm, "_wraps"}, w, vecs[i].wraps);
      check({nm, "_static"}, e, 0);
    end

    // Wrap timing with P=0: pulse appears exactly 256 clocks after release.
    do_reset(8'h04, 8'h00, "wrap_pos");
    run(255, h, w, e, 4'b0100);
    check("wrap_pos_before", w, 0);
    run(1, h, w, e, 4'b0100);
    check("wrap_pos_at", w, 1);

    // Select change mid-period takes effect only at the wrap.
    do_reset(8'h02, 8'h00, "sel_chg");
    run(100, h, w, e, 4'b0010);
    ui_in = 8'h06;
    run(155, h2, w2, e2, 4'b0010);
    check("sel_chg_p1_highs", h + h2, 64);
    check("sel_chg_p1_static", e + e2, 0);
    run(1, h, w, e, 4'b0110);
    check("sel_chg_wrap", w, 1);
    check("sel_chg_new_sel", int'(uo_out[5:3]), 6);
    run(256, h, w, e, 4'b0110);
    check("sel_chg_p2_highs", h, 192);
    check("sel_chg_p2_static", e, 0);

    // Enable pause mid-period: outputs low, counting resumes from held point.
    do_reset(8'h04, 8'h00, "ena_pause");
    run(50, h, w, e, 4'b0100);
    check("ena_pause_pre_highs", h, 50);
    ena = 1'b0;
    #1;
    e = 0;
    for (int k = 0; k < 50; k++) begin
      if (uo_out[2:0] !== 3'b000) e++;
      step();
    end
    if (uo_out[2:0] !== 3'b000) e++;
    check("ena_pause_low", e, 0);
    ena = 1'b1;
    run(205, h, w, e, 4'b0100);
    check("ena_pause_rem_highs", h, 78);
    check("ena_pause_no_early_wrap", w, 0);
    run(1, h, w, e, 4'b0100);
    check("ena_pause_wrap", w, 1);

    // Reset asserted mid-period with ena low still clears the counters.
    do_reset(8'h04, 8'h00, "mid_rst");
    run(30, h, w, e, 4'b0100);
    ena   = 1'b0;
    rst_n = 1'b1;
    step();
    check("mid_rst_low", int'(uo_out[2:0]), 0);
    ena = 1'b1;
    step();
    check("mid_rst_low_ena", int'(uo_out[2:0]), 0);
    rst_n = 1'b0;
    run(256, h, w, e, 4'b0100);
    check("mid_rst_highs", h, 128);
    check("mid_rst_wraps", w, 1);
    check("mid_rst_static", e, 0);

    check("uio_constant", uio_errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
